multicycle_ctrl: RTL and testbench

Parametrised main controller for the multicycle MIPS core. It replaces the fixed LW/SW/R-type/BEQ/ADDI/J state machine with an extended instruction set: BNE, ANDI, ORI and SLTI. It supports variable-latency memory through a ready handshake and traps illegal opcodes to an exception vector. It sits between the instruction register's opcode field and the datapath/ALU decoder, and drives all datapath strobes and muxes.

---
 rtl/mips_ctrl_pkg.sv | 64 ++++++
 rtl/multicycle_ctrl_if.sv | 38 +++
 rtl/ctrl_outdec.sv | 74 +++++++
 rtl/multicycle_ctrl.sv | 82 ++++++++
 tb/tb_multicycle_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared types and encodings for the multicycle MIPS controller.
// Holds the state enum, opcode/aluop/mux encodings, the packed control word
// carried from the output decoder to the top, and the I-type aluop helper.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_IEXEC, S_IWB, S_JUMP, S_TRAP
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_EXC    = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       branch;
        logic       branch_ne;
        logic       zeroext;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic [2:0] imm_aluop(input logic [5:0] op);
        return op == OP_ANDI ? ALU_AND :
               op == OP_ORI  ? ALU_OR  :
               op == OP_SLTI ? ALU_SLT : ALU_ADD;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath bundle.
// master (controller): receives op/mem_ready, drives every strobe, mux select
// and the state_dbg debug view. slave (datapath side): the mirror image.
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       mem_req;
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       memwrite;
    logic       regwrite;
    logic       branch;
    logic       branch_ne;
    logic       zeroext;
    logic [2:0] aluop;
    logic       illegal_op;
    logic [3:0] state_dbg;

    modport master (
        input  op, mem_ready,
        output mem_req, memtoreg, regdst, iord, alusrca, alusrcb, pcsrc,
               irwrite, pcwrite, memwrite, regwrite, branch, branch_ne,
               zeroext, aluop, illegal_op, state_dbg
    );

    modport slave (
        output op, mem_ready,
        input  mem_req, memtoreg, regdst, iord, alusrca, alusrcb, pcsrc,
               irwrite, pcwrite, memwrite, regwrite, branch, branch_ne,
               zeroext, aluop, illegal_op, state_dbg
    );
endinterface

// File: rtl/ctrl_outdec.sv
// ctrl_outdec: combinational control-word decode for the multicycle controller.
// Ports: state (current FSM state), op_q (opcode latched in DECODE),
// done (current memory access completes), c (full control word).
module ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op_q,
    input  logic       done,
    output ctrl_t      c
);
    always_comb begin
        c = '0;
        case (state)
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.alusrcb = SRCB_FOUR;
                // IR and PC only commit once the fetch actually returns data
                c.irwrite = done;
                c.pcwrite = done;
            end
            S_DECODE: c.alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req  = 1'b1;
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = ALU_FUNCT;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca   = 1'b1;
                c.aluop     = ALU_SUB;
                c.pcsrc     = PC_ALUOUT;
                c.branch    = op_q == OP_BEQ;
                c.branch_ne = op_q == OP_BNE;
            end
            S_IEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = imm_aluop(op_q);
                c.zeroext = op_q == OP_ANDI || op_q == OP_ORI;
            end
            S_IWB: c.regwrite = 1'b1;
            S_JUMP: begin
                c.pcsrc   = PC_JUMP;
                c.pcwrite = 1'b1;
            end
            S_TRAP: begin
                c.pcsrc      = PC_EXC;
                c.pcwrite    = 1'b1;
                c.illegal_op = 1'b1;
            end
            default: c = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main FSM controller for the multicycle MIPS core.
// Ports: clk, reset (sync, active-high), bus (master modport: op/mem_ready in,
// all datapath strobes, mux selects, aluop, illegal_op and state_dbg out).
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit EN_BNE        = 1'b1,
    parameter bit EN_IMM_LOGIC  = 1'b1
) (
    input logic             clk,
    input logic             reset,
    multicycle_ctrl_if.master bus
);
    state_t     state, state_n;
    logic [5:0] op_q;
    logic       done;
    ctrl_t      c, o;

    assign done = !MEM_HANDSHAKE || bus.mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            op_q  <= '0;
        end else begin
            state <= state_n;
            if (state == S_DECODE) op_q <= bus.op;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:  state_n = done ? S_DECODE : S_FETCH;
            S_DECODE: case (bus.op)
                OP_LW, OP_SW:              state_n = S_MEMADR;
                OP_R:                      state_n = S_EXEC;
                OP_BEQ:                    state_n = S_BRANCH;
                OP_BNE:                    state_n = EN_BNE ? S_BRANCH : S_TRAP;
                OP_ADDI:                   state_n = S_IEXEC;
                OP_ANDI, OP_ORI, OP_SLTI:  state_n = EN_IMM_LOGIC ? S_IEXEC : S_TRAP;
                OP_J:                      state_n = S_JUMP;
                default:                   state_n = S_TRAP;
            endcase
            S_MEMADR: state_n = op_q == OP_LW ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_n = done ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_n = done ? S_FETCH : S_MEMWR;
            S_EXEC:   state_n = S_ALUWB;
            S_BRANCH: state_n = S_FETCH;
            S_IEXEC:  state_n = S_IWB;
            default:  state_n = S_FETCH;
        endcase
    end

    ctrl_outdec u_outdec (
        .state (state),
        .op_q  (op_q),
        .done  (done),
        .c     (c)
    );

    // Everything is forced low while reset is held, even before the first edge.
    assign o              = reset ? '0 : c;
    assign bus.state_dbg  = reset ? 4'd0 : state;
    assign bus.mem_req    = o.mem_req;
    assign bus.iord       = o.iord;
    assign bus.irwrite    = o.irwrite;
    assign bus.pcwrite    = o.pcwrite;
    assign bus.memwrite   = o.memwrite;
    assign bus.regwrite   = o.regwrite;
    assign bus.memtoreg   = o.memtoreg;
    assign bus.regdst     = o.regdst;
    assign bus.alusrca    = o.alusrca;
    assign bus.alusrcb    = o.alusrcb;
    assign bus.pcsrc      = o.pcsrc;
    assign bus.aluop      = o.aluop;
    assign bus.branch     = o.branch;
    assign bus.branch_ne  = o.branch_ne;
    assign bus.zeroext    = o.zeroext;
    assign bus.illegal_op = o.illegal_op;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed table-driven bench for multicycle_ctrl plus
// hand sequences for the no-handshake and disabled-opcode variants.
module tb_multicycle_ctrl;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                           ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010,
                           JMP = 6'b000010, BAD = 6'b111111;

    // Control word bit order: mem_req iord irwrite pcwrite | memwrite regwrite
    // memtoreg regdst | alusrca | alusrcb | pcsrc | aluop | branch branch_ne zeroext illegal_op
    localparam logic [19:0] ZERO   = 20'b0000_0000_0_00_00_000_0000;
    localparam logic [19:0] F_WAIT = 20'b1000_0000_0_01_00_000_0000;
    localparam logic [19:0] F_DONE = 20'b1011_0000_0_01_00_000_0000;
    localparam logic [19:0] DEC    = 20'b0000_0000_0_11_00_000_0000;
    localparam logic [19:0] MADR   = 20'b0000_0000_1_10_00_000_0000;
    localparam logic [19:0] MRD    = 20'b1100_0000_0_00_00_000_0000;
    localparam logic [19:0] MWB    = 20'b0000_0110_0_00_00_000_0000;
    localparam logic [19:0] MWR    = 20'b1100_1000_0_00_00_000_0000;
    localparam logic [19:0] EXE    = 20'b0000_0000_1_00_00_010_0000;
    localparam logic [19:0] AWB    = 20'b0000_0101_0_00_00_000_0000;
    localparam logic [19:0] BR_EQ  = 20'b0000_0000_1_00_01_001_1000;
    localparam logic [19:0] BR_NE  = 20'b0000_0000_1_00_01_001_0100;
    localparam logic [19:0] IX_ADD = 20'b0000_0000_1_10_00_000_0000;
    localparam logic [19:0] IX_AND = 20'b0000_0000_1_10_00_011_0010;
    localparam logic [19:0] IX_OR  = 20'b0000_0000_1_10_00_100_0010;
    localparam logic [19:0] IX_SLT = 20'b0000_0000_1_10_00_101_0000;
    localparam logic [19:0] IWB    = 20'b0000_0100_0_00_00_000_0000;
    localparam logic [19:0] JUMP   = 20'b0001_0000_0_00_10_000_0000;
    localparam logic [19:0] TRAP   = 20'b0001_0000_0_00_11_000_0001;

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [19:0] ctl;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();
    multicycle_ctrl_if bus_nh ();
    multicycle_ctrl_if bus_nb ();

    multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    multicycle_ctrl #(.MEM_HANDSHAKE(1'b0)) dut_nh (.clk(clk), .reset(reset), .bus(bus_nh));
    multicycle_ctrl #(.EN_BNE(1'b0), .EN_IMM_LOGIC(1'b0)) dut_nb (.clk(clk), .reset(reset), .bus(bus_nb));

    function automatic logic [23:0] obs();
        return {bus.state_dbg, bus.mem_req, bus.iord, bus.irwrite, bus.pcwrite,
                bus.memwrite, bus.regwrite, bus.memtoreg, bus.regdst, bus.alusrca,
                bus.alusrcb, bus.pcsrc, bus.aluop, bus.branch, bus.branch_ne,
                bus.zeroext, bus.illegal_op};
    endfunction

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic add(input string nm, input logic r, input logic [5:0] o,
                       input logic rd, input logic [3:0] s, input logic [19:0] c);
        vq.push_back('{nm, r, o, rd, s, c});
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    // Disabled-opcode variant: after reset, cycle 2 is the state reached from DECODE.
    task automatic nb_run(input string nm, input logic [5:0] o, input logic [3:0] st,
                          input logic ill, input logic [1:0] pc, input logic pcw);
        bus_nb.op = o;
        do_reset();
        repeat (2) @(negedge clk);
        #1 chk(nm, {16'd0, bus_nb.state_dbg, bus_nb.illegal_op, bus_nb.pcsrc, bus_nb.pcwrite},
               {16'd0, st, ill, pc, pcw});
        if (ill) begin
            @(negedge clk);
            #1 chk({nm, "_after"}, {19'd0, bus_nb.state_dbg, bus_nb.illegal_op}, {19'd0, 4'd0, 1'b0});
        end
    endtask

    initial begin
        bus.op = RT;    bus.mem_ready = 1'b0;
        bus_nh.op = RT; bus_nh.mem_ready = 1'b0;
        bus_nb.op = RT; bus_nb.mem_ready = 1'b1;

        add("reset",      1, RT, 0, 0, ZERO);
        add("reset_rdy",  1, RT, 1, 0, ZERO);
        add("lw_fw1",     0, LW, 0, 0, F_WAIT);
        add("lw_fw2",     0, LW, 0, 0, F_WAIT);
        add("lw_fetch",   0, LW, 1, 0, F_DONE);
        add("lw_dec",     0, LW, 0, 1, DEC);
        add("lw_madr",    0, SW, 0, 2, MADR);
        add("lw_rd_wait", 0, SW, 0, 3, MRD);
        add("lw_rd",      0, SW, 1, 3, MRD);
        add("lw_wb",      0, SW, 1, 4, MWB);
        add("r_fetch",    0, RT, 1, 0, F_DONE);
        add("r_dec",      0, RT, 0, 1, DEC);
        add("r_exec",     0, RT, 1, 6, EXE);
        add("r_wb",       0, RT, 0, 7, AWB);
        add("beq_fetch",  0, BEQ, 1, 0, F_DONE);
        add("beq_dec",    0, BEQ, 1, 1, DEC);
        add("beq_br",     0, BEQ, 1, 8, BR_EQ);
        add("bne_fetch",  0, BNE, 1, 0, F_DONE);
        add("bne_dec",    0, BNE, 1, 1, DEC);
        add("bne_br",     0, BNE, 1, 8, BR_NE);
        add("ori_fetch",  0, ORI, 1, 0, F_DONE);
        add("ori_dec",    0, ORI, 1, 1, DEC);
        add("ori_iexec",  0, ORI, 1, 9, IX_OR);
        add("ori_iwb",    0, ORI, 1, 10, IWB);
        add("andi_fetch", 0, ANDI, 1, 0, F_DONE);
        add("andi_dec",   0, ANDI, 1, 1, DEC);
        add("andi_iexec", 0, ANDI, 1, 9, IX_AND);
        add("andi_iwb",   0, ANDI, 1, 10, IWB);
        add("slti_fetch", 0, SLTI, 1, 0, F_DONE);
        add("slti_dec",   0, SLTI, 1, 1, DEC);
        add("slti_iexec", 0, SLTI, 1, 9, IX_SLT);
        add("slti_iwb",   0, SLTI, 1, 10, IWB);
        add("addi_fetch", 0, ADDI, 1, 0, F_DONE);
        add("addi_dec",   0, ADDI, 1, 1, DEC);
        add("addi_iexec", 0, ADDI, 1, 9, IX_ADD);
        add("addi_iwb",   0, ADDI, 1, 10, IWB);
        add("j_fetch",    0, JMP, 1, 0, F_DONE);
        add("j_dec",      0, JMP, 1, 1, DEC);
        add("j_jump",     0, JMP, 1, 11, JUMP);
        add("bad_fetch",  0, BAD, 1, 0, F_DONE);
        add("bad_dec",    0, BAD, 1, 1, DEC);
        add("bad_trap",   0, BAD, 1, 12, TRAP);
        add("trap_next",  0, SW, 1, 0, F_DONE);
        add("swr_dec",    0, SW, 0, 1, DEC);
        add("swr_madr",   0, SW, 0, 2, MADR);
        add("swr_wait1",  0, SW, 0, 5, MWR);
        add("swr_wait2",  0, SW, 0, 5, MWR);
        add("swr_rst1",   1, SW, 0, 0, ZERO);
        add("swr_rst2",   1, SW, 0, 0, ZERO);
        add("swr_fetch",  0, SW, 1, 0, F_DONE);
        add("sw_dec",     0, SW, 0, 1, DEC);
        add("sw_madr",    0, SW, 0, 2, MADR);
        add("sw_wr",      0, SW, 1, 5, MWR);
        add("sw_next",    0, RT, 1, 0, F_DONE);

        repeat (2) @(posedge clk);
        foreach (vq[i]) begin
            @(negedge clk);
            reset = vq[i].rst;
            bus.op = vq[i].op;
            bus.mem_ready = vq[i].rdy;
            #1 chk(vq[i].name, obs(), {vq[i].st, vq[i].ctl});
        end

        begin
            int  cyc = 0, mw = 0, mwi = 0;
            logic fin = 1'b0;
            bus_nh.op = SW;
            bus_nh.mem_ready = 1'b0;
            do_reset();
            for (int i = 0; i < 12; i++) begin
                #1;
                if (i > 0 && bus_nh.state_dbg == 4'd0) begin
                    fin = 1'b1;
                    break;
                end
                cyc++;
                mw += int'(bus_nh.memwrite);
                mwi += int'(bus_nh.memwrite && bus_nh.iord);
                @(negedge clk);
            end
            chk("nh_sw_done",    {23'd0, fin}, 24'd1);
            chk("nh_sw_cycles",  24'(cyc), 24'd4);
            chk("nh_sw_memwr",   24'(mw), 24'd1);
            chk("nh_sw_memwr_iord", 24'(mwi), 24'd1);
        end

        nb_run("nb_bne_trap",  BNE,  4'd12, 1'b1, 2'b11, 1'b1);
        nb_run("nb_ori_trap",  ORI,  4'd12, 1'b1, 2'b11, 1'b1);
        nb_run("nb_addi_ok",   ADDI, 4'd9,  1'b0, 2'b00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
